// File: rtl/sensor_scan_sequencer.sv
// Periodic multi-channel sensor scanner: every scan period it walks the enabled
// channels in ascending order, runs the initiate/ready handshake on each one and
// streams one checksummed frame per channel to a byte-wide valid/ready sink.
module sensor_scan_sequencer #(
  parameter int         NUM_SENSORS    = 4,
  parameter int         DATA_WIDTH     = 16,
  parameter int         PERIOD_CYCLES  = 50_000_000,
  parameter int         TIMEOUT_CYCLES = 1_000_000,
  parameter logic [7:0] SYNC_BYTE      = 8'hA5
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              enable,
  input  logic [NUM_SENSORS-1:0]            sensor_mask,
  output logic [NUM_SENSORS-1:0]            sensor_initiate,
  input  logic [NUM_SENSORS-1:0]            sensor_ready,
  input  logic [NUM_SENSORS*DATA_WIDTH-1:0] sensor_data,
  output logic [7:0]                        tx_data,
  output logic                              tx_valid,
  input  logic                              tx_ready,
  output logic                              busy,
  output logic [3:0]                        current_sensor,
  output logic                              overrun,
  output logic [7:0]                        timeout_count
);

  localparam int NB    = (DATA_WIDTH + 7) / 8;
  localparam int EXT_W = NB * 8;
  localparam int PW    = (PERIOD_CYCLES > 1) ? $clog2(PERIOD_CYCLES) : 1;
  localparam int TW    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [PW-1:0] PERIOD_LAST  = PW'(PERIOD_CYCLES - 1);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [2:0]    LAST_BYTE    = 3'(NB + 2);

  typedef enum logic [2:0] {IDLE, REQUEST, WAIT_BUSY, WAIT_DONE, SEND, NEXT} state_t;

  state_t                  state_q, state_d;
  logic [PW-1:0]           period_q, period_d;
  logic [TW-1:0]           tmo_q, tmo_d;
  logic [NUM_SENSORS-1:0]  mask_q, mask_d;
  logic [3:0]              idx_q, idx_d;
  logic [DATA_WIDTH-1:0]   data_q, data_d;
  logic                    status_q, status_d;
  logic [7:0]              tcount_q, tcount_d;
  logic [2:0]              byte_q, byte_d;
  logic                    tx_valid_q, tx_valid_d;
  logic [7:0]              tx_data_q, tx_data_d;

  logic                    tick;
  logic                    ready_sel;
  logic [DATA_WIDTH-1:0]   data_sel;
  logic [3:0]              first_idx;
  logic [3:0]              next_idx;
  logic                    next_found;
  logic                    start_pulse;
  logic                    do_timeout;
  logic [EXT_W-1:0]        data_ext;
  logic [7:0]              status_byte;
  logic [7:0]              checksum;
  logic [2:0]              byte_sel;
  logic [7:0]              frame_byte;

  assign tick           = (period_q == PERIOD_LAST);
  assign busy           = (state_q != IDLE);
  assign overrun        = tick & busy;
  assign current_sensor = idx_q;
  assign timeout_count  = tcount_q;
  assign tx_valid       = tx_valid_q;
  assign tx_data        = tx_data_q;

  // Select the serviced channel's ready/data and find the first and next enabled channels.
  always_comb begin
    ready_sel  = 1'b0;
    data_sel   = '0;
    first_idx  = '0;
    next_idx   = '0;
    next_found = 1'b0;
    for (int i = NUM_SENSORS - 1; i >= 0; i--) begin
      if (idx_q == 4'(i)) begin
        ready_sel = sensor_ready[i];
        data_sel  = sensor_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
      if (sensor_mask[i]) first_idx = 4'(i);
      if (mask_q[i] && (4'(i) > idx_q)) begin
        next_idx   = 4'(i);
        next_found = 1'b1;
      end
    end
  end

  // Build the frame byte to present next: the current index before the first
  // transfer, otherwise the one after the byte currently on the bus.
  always_comb begin
    data_ext    = EXT_W'(data_q);
    status_byte = {status_q, 3'b000, idx_q};
    checksum    = status_byte;
    for (int j = 0; j < NB; j++) checksum = checksum ^ data_ext[j*8 +: 8];
    byte_sel   = tx_valid_q ? (byte_q + 3'd1) : byte_q;
    frame_byte = 8'h00;
    if (byte_sel == 3'd0) begin
      frame_byte = SYNC_BYTE;
    end else if (byte_sel == 3'd1) begin
      frame_byte = status_byte;
    end else if (byte_sel == LAST_BYTE) begin
      frame_byte = checksum;
    end else begin
      for (int j = 0; j < NB; j++) begin
        if (byte_sel == 3'(j + 2)) frame_byte = data_ext[(NB-1-j)*8 +: 8];
      end
    end
  end

  // Next-state logic for the scan FSM, the conversion timeout and the byte stream.
  always_comb begin
    state_d     = state_q;
    period_d    = tick ? '0 : period_q + PW'(1);
    tmo_d       = tmo_q;
    mask_d      = mask_q;
    idx_d       = idx_q;
    data_d      = data_q;
    status_d    = status_q;
    tcount_d    = tcount_q;
    byte_d      = byte_q;
    tx_valid_d  = tx_valid_q;
    tx_data_d   = tx_data_q;
    start_pulse = 1'b0;
    do_timeout  = 1'b0;
    case (state_q)
      IDLE: begin
        if (tick && enable) begin
          mask_d = sensor_mask;
          if (|sensor_mask) begin
            idx_d   = first_idx;
            tmo_d   = '0;
            state_d = REQUEST;
          end
        end
      end
      REQUEST: begin
        tmo_d = tmo_q + TW'(1);
        if (tmo_q == TIMEOUT_LAST) begin
          do_timeout = 1'b1;
        end else if (ready_sel) begin
          start_pulse = 1'b1;
          state_d     = WAIT_BUSY;
        end
      end
      WAIT_BUSY: begin
        tmo_d = tmo_q + TW'(1);
        if (tmo_q == TIMEOUT_LAST) begin
          do_timeout = 1'b1;
        end else if (!ready_sel) begin
          state_d = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        tmo_d = tmo_q + TW'(1);
        if (ready_sel) begin
          data_d   = data_sel;
          status_d = 1'b0;
          byte_d   = '0;
          state_d  = SEND;
        end else if (tmo_q == TIMEOUT_LAST) begin
          do_timeout = 1'b1;
        end
      end
      SEND: begin
        if (!tx_valid_q) begin
          tx_valid_d = 1'b1;
          tx_data_d  = frame_byte;
        end else if (tx_ready) begin
          if (byte_q == LAST_BYTE) begin
            tx_valid_d = 1'b0;
            state_d    = NEXT;
          end else begin
            byte_d    = byte_q + 3'd1;
            tx_data_d = frame_byte;
          end
        end
      end
      NEXT: begin
        if (next_found) begin
          idx_d   = next_idx;
          tmo_d   = '0;
          state_d = REQUEST;
        end else begin
          idx_d   = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (do_timeout) begin
      data_d   = '0;
      status_d = 1'b1;
      tcount_d = (tcount_q != 8'hFF) ? tcount_q + 8'd1 : tcount_q;
      byte_d   = '0;
      state_d  = SEND;
    end
  end

  // Initiate strobe goes only to the channel being serviced.
  always_comb begin
    sensor_initiate = '0;
    for (int i = 0; i < NUM_SENSORS; i++) begin
      sensor_initiate[i] = start_pulse && (idx_q == 4'(i));
    end
  end

  // State registers; reset clears everything including the stream valid.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      period_q   <= '0;
      tmo_q      <= '0;
      mask_q     <= '0;
      idx_q      <= '0;
      data_q     <= '0;
      status_q   <= 1'b0;
      tcount_q   <= '0;
      byte_q     <= '0;
      tx_valid_q <= 1'b0;
      tx_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      period_q   <= period_d;
      tmo_q      <= tmo_d;
      mask_q     <= mask_d;
      idx_q      <= idx_d;
      data_q     <= data_d;
      status_q   <= status_d;
      tcount_q   <= tcount_d;
      byte_q     <= byte_d;
      tx_valid_q <= tx_valid_d;
      tx_data_q  <= tx_data_d;
    end
  end

endmodule

// File: tb/tb_sensor_scan_sequencer.sv
// Directed bench for sensor_scan_sequencer: one instance with the main bench
// parameters and a second one with a short period / long timeout for overrun.
module tb_sensor_scan_sequencer;

  localparam int NS = 3;
  localparam int DW = 12;

  logic            clk = 1'b0;
  logic            reset;
  logic            enable;
  logic [NS-1:0]   sensor_mask;
  logic [NS-1:0]   sensor_initiate;
  logic [NS-1:0]   sensor_ready = 3'b111;
  logic [NS*DW-1:0] sensor_data = '0;
  logic [7:0]      tx_data;
  logic            tx_valid;
  logic            tx_ready = 1'b1;
  logic            busy;
  logic [3:0]      current_sensor;
  logic            overrun;
  logic [7:0]      timeout_count;

  logic            enable_b;
  logic [NS-1:0]   sensor_mask_b;
  logic [NS-1:0]   sensor_initiate_b;
  logic [NS-1:0]   sensor_ready_b;
  logic [NS*DW-1:0] sensor_data_b;
  logic [7:0]      tx_data_b;
  logic            tx_valid_b;
  logic            tx_ready_b;
  logic            busy_b;
  logic [3:0]      current_sensor_b;
  logic            overrun_b;
  logic [7:0]      timeout_count_b;

  int tests_run = 0;
  int tests_failed = 0;

  logic       rnd_mode = 1'b0;
  logic       ready_level = 1'b1;
  logic [DW-1:0] sdata [NS];
  logic       hold [NS];
  int         phase [NS];
  int         scnt [NS];

  logic [7:0] rx_q [$];
  logic       stall_pend = 1'b0;
  logic [7:0] stall_data = 8'h00;
  int         stall_err = 0;
  int         init_cnt [NS];
  int         init_run = 0;
  int         init_max_run = 0;
  int         multi_err = 0;
  int         ovr_a_cnt = 0;
  int         ovr_b_cnt = 0;
  int         init_b_cnt = 0;
  int         busy_b_seen = 0;

  sensor_scan_sequencer #(
    .NUM_SENSORS(NS), .DATA_WIDTH(DW), .PERIOD_CYCLES(1000),
    .TIMEOUT_CYCLES(200), .SYNC_BYTE(8'hA5)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .sensor_mask(sensor_mask),
    .sensor_initiate(sensor_initiate), .sensor_ready(sensor_ready),
    .sensor_data(sensor_data), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .busy(busy), .current_sensor(current_sensor),
    .overrun(overrun), .timeout_count(timeout_count)
  );

  sensor_scan_sequencer #(
    .NUM_SENSORS(NS), .DATA_WIDTH(DW), .PERIOD_CYCLES(300),
    .TIMEOUT_CYCLES(1000), .SYNC_BYTE(8'hA5)
  ) dut_ovr (
    .clk(clk), .reset(reset), .enable(enable_b), .sensor_mask(sensor_mask_b),
    .sensor_initiate(sensor_initiate_b), .sensor_ready(sensor_ready_b),
    .sensor_data(sensor_data_b), .tx_data(tx_data_b), .tx_valid(tx_valid_b),
    .tx_ready(tx_ready_b), .busy(busy_b), .current_sensor(current_sensor_b),
    .overrun(overrun_b), .timeout_count(timeout_count_b)
  );

  always #5 clk = ~clk;

  // Sink ready is updated just after each rising edge, either fixed or ~30% random.
  always @(posedge clk) begin
    #1;
    tx_ready = rnd_mode ? ($urandom_range(0, 99) < 30) : ready_level;
  end

  // Monitor on the falling edge: record accepted bytes, watch stall stability and
  // initiate behaviour, count overruns, then advance the behavioural sensor models.
  always @(negedge clk) begin
    if (tx_valid && tx_ready) rx_q.push_back(tx_data);
    if (stall_pend && tx_valid && (tx_data !== stall_data)) stall_err++;
    stall_pend = tx_valid && !tx_ready;
    stall_data = tx_data;
    for (int i = 0; i < NS; i++) if (sensor_initiate[i]) init_cnt[i]++;
    if (sensor_initiate != '0) begin
      init_run++;
      if (init_run > init_max_run) init_max_run = init_run;
    end else begin
      init_run = 0;
    end
    if (($countones(sensor_initiate) > 1) || ((sensor_initiate != '0) && !busy)) multi_err++;
    if (overrun) ovr_a_cnt++;
    if (overrun_b) ovr_b_cnt++;
    if (sensor_initiate_b != '0) init_b_cnt++;
    if (busy_b) busy_b_seen++;
    for (int i = 0; i < NS; i++) begin
      case (phase[i])
        0: if (sensor_initiate[i] && !hold[i]) begin phase[i] = 1; scnt[i] = 0; end
        1: begin
          scnt[i]++;
          if (scnt[i] == 5) begin sensor_ready[i] = 1'b0; phase[i] = 2; scnt[i] = 0; end
        end
        2: begin
          scnt[i]++;
          if (scnt[i] == 20) begin
            sensor_data[i*DW +: DW] = sdata[i];
            sensor_ready[i] = 1'b1;
            phase[i] = 0;
          end
        end
        default: phase[i] = 0;
      endcase
    end
  end

  // Single comparison point: counts every check and reports failures.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Program the scan mask and the sink ready mode for the next scan.
  task automatic applyStimulus(input logic [NS-1:0] mask, input logic rnd);
    sensor_mask = mask;
    rnd_mode    = rnd;
    ready_level = 1'b1;
  endtask

  // Wait (bounded) for busy to reach a level; an expired bound shows up as a failed check.
  task automatic waitBusy(input logic level, input int limit, input string tag);
    int n = 0;
    while ((busy !== level) && (n < limit)) begin @(negedge clk); n++; end
    checkOutput(tag, 32'(busy), 32'(level));
  endtask

  // Collect one five-byte frame from the sink and compare byte by byte.
  task automatic checkFrame(input string tag, input logic [39:0] exp);
    int n = 0;
    logic [7:0] got;
    while ((rx_q.size() < 5) && (n < 400)) begin @(negedge clk); n++; end
    for (int k = 0; k < 5; k++) begin
      if (rx_q.size() > 0) got = rx_q.pop_front();
      else got = 8'hxx;
      checkOutput($sformatf("%s byte%0d", tag, k), 32'(got), 32'(exp[39-8*k -: 8]));
    end
  endtask

  // Directed test sequence.
  initial begin
    int n;
    int base0, base1, base2, base_ovr, base_init, base_busy;
    for (int i = 0; i < NS; i++) begin
      sdata[i] = '0; hold[i] = 1'b0; phase[i] = 0; scnt[i] = 0; init_cnt[i] = 0;
    end
    reset = 1'b0;
    enable = 1'b1;
    sensor_mask = '0;
    enable_b = 1'b0;
    sensor_mask_b = 3'b001;
    sensor_ready_b = 3'b111;
    sensor_data_b = '0;
    tx_ready_b = 1'b1;
    repeat (3) @(negedge clk);

    checkOutput("reset busy", 32'(busy), 32'd0);
    checkOutput("reset tx_valid", 32'(tx_valid), 32'd0);
    checkOutput("reset current_sensor", 32'(current_sensor), 32'd0);
    checkOutput("reset timeout_count", 32'(timeout_count), 32'd0);
    checkOutput("reset initiate", 32'(sensor_initiate), 32'd0);
    checkOutput("reset overrun", 32'(overrun), 32'd0);
    #1 reset = 1'b1;

    // Single channel, clean handshake.
    $display("[TB] scenario: mask 001, data ABC");
    sdata[0] = 12'hABC;
    applyStimulus(3'b001, 1'b0);
    base0 = init_cnt[0];
    waitBusy(1'b1, 1100, "s1 scan start");
    checkFrame("s1", 40'hA5_00_0A_BC_B6);
    checkOutput("s1 busy at last byte", 32'(busy), 32'd1);
    waitBusy(1'b0, 20, "s1 busy fall");
    checkOutput("s1 no extra bytes", 32'(rx_q.size()), 32'd0);
    checkOutput("s1 initiate count ch0", 32'(init_cnt[0] - base0), 32'd1);
    checkOutput("s1 initiate width", 32'(init_max_run), 32'd1);

    // Two channels with a gap in the mask.
    $display("[TB] scenario: mask 101");
    sdata[0] = 12'h123;
    sdata[2] = 12'h0FF;
    applyStimulus(3'b101, 1'b0);
    base1 = init_cnt[1];
    base2 = init_cnt[2];
    waitBusy(1'b1, 1100, "s2 scan start");
    checkFrame("s2 ch0", 40'hA5_00_01_23_22);
    checkFrame("s2 ch2", 40'hA5_02_00_FF_FD);
    waitBusy(1'b0, 20, "s2 busy fall");
    checkOutput("s2 ch1 never initiated", 32'(init_cnt[1] - base1), 32'd0);
    checkOutput("s2 ch2 initiated once", 32'(init_cnt[2] - base2), 32'd1);

    // Sensor 2 never starts converting: timeout frame after exactly 200 cycles.
    $display("[TB] scenario: timeout on ch2");
    hold[2] = 1'b1;
    applyStimulus(3'b100, 1'b0);
    checkOutput("s3 timeout_count before", 32'(timeout_count), 32'd0);
    waitBusy(1'b1, 1100, "s3 scan start");
    checkOutput("s3 current_sensor", 32'(current_sensor), 32'd2);
    n = 0;
    while (!tx_valid && (n < 400)) begin @(negedge clk); n++; end
    checkOutput("s3 cycles to first valid", 32'(n), 32'd201);
    checkFrame("s3", 40'hA5_82_00_00_82);
    waitBusy(1'b0, 20, "s3 busy fall");
    checkOutput("s3 timeout_count", 32'(timeout_count), 32'd1);
    checkOutput("s3 idle current_sensor", 32'(current_sensor), 32'd0);
    hold[2] = 1'b0;

    // Random back-pressure from the sink.
    $display("[TB] scenario: random tx_ready");
    sdata[0] = 12'hABC;
    applyStimulus(3'b001, 1'b1);
    waitBusy(1'b1, 1100, "s4 scan start");
    checkFrame("s4", 40'hA5_00_0A_BC_B6);
    waitBusy(1'b0, 40, "s4 busy fall");
    rnd_mode = 1'b0;
    checkOutput("s4 stall stability errors", 32'(stall_err), 32'd0);

    // Reset in the middle of a frame, then a fresh scan.
    $display("[TB] scenario: reset mid-frame");
    applyStimulus(3'b001, 1'b0);
    waitBusy(1'b1, 1100, "s6 scan start");
    n = 0;
    while ((rx_q.size() < 2) && (n < 400)) begin @(negedge clk); n++; #1; end
    ready_level = 1'b0;
    @(negedge clk);
    checkOutput("s6 stalled on byte2", 32'(tx_data), 32'h0A);
    #1 reset = 1'b0;
    #1;
    checkOutput("s6 tx_valid after reset", 32'(tx_valid), 32'd0);
    checkOutput("s6 busy after reset", 32'(busy), 32'd0);
    rx_q.delete();
    ready_level = 1'b1;
    @(negedge clk);
    #1 reset = 1'b1;
    n = 0;
    while (!busy && (n < 1200)) begin @(negedge clk); n++; end
    checkOutput("s6 first tick latency", 32'(n), 32'd1000);
    checkFrame("s6 fresh", 40'hA5_00_0A_BC_B6);
    waitBusy(1'b0, 20, "s6 busy fall");

    // Overrun: conversion held across a period tick on the short-period instance.
    $display("[TB] scenario: overrun");
    checkOutput("s5 disabled never busy", 32'(busy_b_seen), 32'd0);
    base_ovr = ovr_b_cnt;
    base_init = init_b_cnt;
    enable_b = 1'b1;
    n = 0;
    while (!sensor_initiate_b[0] && (n < 400)) begin @(negedge clk); n++; end
    checkOutput("s5 initiate seen", 32'(sensor_initiate_b[0]), 32'd1);
    @(posedge clk);
    #1 sensor_ready_b[0] = 1'b0;
    repeat (450) @(posedge clk);
    #1;
    sensor_data_b[DW-1:0] = 12'h05A;
    sensor_ready_b[0] = 1'b1;
    n = 0;
    while (busy_b && (n < 100)) begin @(negedge clk); n++; end
    checkOutput("s5 busy_b fall", 32'(busy_b), 32'd0);
    checkOutput("s5 overrun pulses", 32'(ovr_b_cnt - base_ovr), 32'd1);
    checkOutput("s5 no restart", 32'(init_b_cnt - base_init), 32'd1);
    checkOutput("s5 no timeout", 32'(timeout_count_b), 32'd0);
    sensor_mask_b = 3'b000;
    base_busy = busy_b_seen;
    repeat (350) @(negedge clk);
    checkOutput("s5 zero mask stays idle", 32'(busy_b_seen - base_busy), 32'd0);
    checkOutput("s5 no overrun when idle", 32'(ovr_b_cnt - base_ovr), 32'd1);

    checkOutput("initiate one-hot and in scan", 32'(multi_err), 32'd0);
    checkOutput("initiate width overall", 32'(init_max_run), 32'd1);
    checkOutput("main instance overruns", 32'(ovr_a_cnt), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
